// File: rtl/truth_table_checker.sv
// Response-side checker for exhaustive combinational tests: records coverage, mismatches and pass/fail.
// Optional per-minterm capture of observed DUT outputs is enabled by defining TTC_LOG_EN.
module truth_table_checker #(
    parameter int                     N_IN     = 4,
    parameter logic [(2**N_IN)-1:0]   EXP_MASK = {(2**N_IN){1'b0}},
    parameter int                     TIMEOUT  = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   vec_valid,
    input  logic [N_IN-1:0]        vec,
    input  logic                   dut_out,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic                   timeout,
    output logic                   dup_seen,
    output logic [N_IN:0]          err_count,
    output logic [(2**N_IN)-1:0]   seen_mask,
    output logic [N_IN-1:0]        first_err_vec,
    output logic                   first_err_vld,
    output logic [(2**N_IN)-1:0]   obs_table
);

    localparam int            D        = 2**N_IN;
    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [N_IN:0] ERR_MAX  = (N_IN+1)'(D);
    localparam logic [N_IN:0] ERR_ONE  = (N_IN+1)'(1);
    localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT);
    localparam logic [CW-1:0] IDLE_ONE = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t          state_r;
    logic [CW-1:0]   idle_cnt_r;
    logic            busy_r;
    logic            done_r;
    logic            pass_r;
    logic            timeout_r;
    logic            dup_r;
    logic [N_IN:0]   err_r;
    logic [D-1:0]    seen_r;
    logic [N_IN-1:0] first_vec_r;
    logic            first_vld_r;

    logic            sample_s;
    logic            new_s;
    logic            dup_s;
    logic            mism_s;
    logic [D-1:0]    seen_next_s;
    logic [N_IN:0]   err_next_s;
    logic [CW-1:0]   idle_next_s;
    logic            all_seen_s;
    logic            expire_s;

    // Classify the current sample and precompute the next coverage/error values
    always_comb begin
        sample_s    = (state_r == ST_COLLECT) && vec_valid && !start;
        new_s       = 1'b0;
        dup_s       = 1'b0;
        if (sample_s) begin
            if (seen_r[vec]) begin
                dup_s = 1'b1;
            end else begin
                new_s = 1'b1;
            end
        end else begin
            new_s = 1'b0;
            dup_s = 1'b0;
        end
        mism_s      = new_s && (dut_out != EXP_MASK[vec]);
        seen_next_s = seen_r;
        if (new_s) begin
            seen_next_s[vec] = 1'b1;
        end else begin
            seen_next_s = seen_r;
        end
        err_next_s  = err_r;
        if (mism_s && (err_r != ERR_MAX)) begin
            err_next_s = err_r + ERR_ONE;
        end else begin
            err_next_s = err_r;
        end
        idle_next_s = idle_cnt_r + IDLE_ONE;
        all_seen_s  = &seen_next_s;
        expire_s    = (idle_next_s == TO_LIMIT);
    end

    // Run-control FSM with all status outputs registered alongside the state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            idle_cnt_r  <= {CW{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            timeout_r   <= 1'b0;
            dup_r       <= 1'b0;
            err_r       <= {(N_IN+1){1'b0}};
            seen_r      <= {D{1'b0}};
            first_vec_r <= {N_IN{1'b0}};
            first_vld_r <= 1'b0;
        end else if (start) begin
            // start restarts from any state and outranks a coincident sample
            state_r     <= ST_COLLECT;
            idle_cnt_r  <= {CW{1'b0}};
            busy_r      <= 1'b1;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            timeout_r   <= 1'b0;
            dup_r       <= 1'b0;
            err_r       <= {(N_IN+1){1'b0}};
            seen_r      <= {D{1'b0}};
            first_vec_r <= {N_IN{1'b0}};
            first_vld_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_IDLE;
                end
                ST_DONE: begin
                    state_r <= ST_DONE;
                end
                ST_COLLECT: begin
                    if (new_s) begin
                        seen_r     <= seen_next_s;
                        err_r      <= err_next_s;
                        idle_cnt_r <= {CW{1'b0}};
                        if (mism_s && !first_vld_r) begin
                            first_vec_r <= vec;
                            first_vld_r <= 1'b1;
                        end else begin
                            first_vld_r <= first_vld_r;
                        end
                        if (all_seen_s) begin
                            state_r <= ST_DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            pass_r  <= (err_next_s == {(N_IN+1){1'b0}}) && !timeout_r;
                        end else begin
                            state_r <= ST_COLLECT;
                        end
                    end else begin
                        if (dup_s) begin
                            dup_r <= 1'b1;
                        end else begin
                            dup_r <= dup_r;
                        end
                        if (expire_s) begin
                            timeout_r <= 1'b1;
                            state_r   <= ST_DONE;
                            busy_r    <= 1'b0;
                            done_r    <= 1'b1;
                            pass_r    <= 1'b0;
                        end else begin
                            idle_cnt_r <= idle_next_s;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    pass_r  <= 1'b0;
                end
            endcase
        end
    end

`ifdef TTC_LOG_EN
    logic [D-1:0] obs_r;

    // Observed-response log, written only on first sight of each minterm
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            obs_r <= {D{1'b0}};
        end else if (start) begin
            obs_r <= {D{1'b0}};
        end else if (new_s) begin
            obs_r[vec] <= dut_out;
        end else begin
            obs_r <= obs_r;
        end
    end

    assign obs_table = obs_r;
`else
    assign obs_table = {D{1'b0}};
`endif

    assign busy          = busy_r;
    assign done          = done_r;
    assign pass          = pass_r;
    assign timeout       = timeout_r;
    assign dup_seen      = dup_r;
    assign err_count     = err_r;
    assign seen_mask     = seen_r;
    assign first_err_vec = first_vec_r;
    assign first_err_vld = first_vld_r;

endmodule
